// File: rtl/skin_segm_pipe.sv
// Purpose : RGB->YCbCr conversion, inclusive Cb/Cr skin window, four-way output mode mux (macro SKIN_COUNT_EN adds a per-frame skin counter).
// Latency : 4 ce-cycles from input to output for pixel data, skin flag, hsync, vsync and de.
// Backpressure: none; ce=0 freezes every register so the stream stalls without bubbles or repeats.
module skin_segm_pipe #(
    parameter int DW     = 8,
    parameter int CB_MIN = 77,
    parameter int CB_MAX = 127,
    parameter int CR_MIN = 133,
    parameter int CR_MAX = 173,
    parameter int CNT_W  = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_de,
    input  logic [DW-1:0]    R,
    input  logic [DW-1:0]    G,
    input  logic [DW-1:0]    B,
    input  logic [1:0]       mode,
    input  logic [DW-1:0]    cb_min,
    input  logic [DW-1:0]    cb_max,
    input  logic [DW-1:0]    cr_min,
    input  logic [DW-1:0]    cr_max,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic             out_de,
    output logic [DW-1:0]    out_c0,
    output logic [DW-1:0]    out_c1,
    output logic [DW-1:0]    out_c2,
    output logic             out_skin,
    output logic [CNT_W-1:0] skin_count,
    output logic             count_valid
);
    localparam int PW = DW + 8;   // unsigned product width
    localparam int SW = DW + 10;  // signed sum width (sign + carry headroom)

    localparam logic signed [SW-1:0] OFF  = SW'(2 ** (DW - 1));
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** DW - 1);

    localparam logic [PW-1:0] K_YR  = PW'(77);
    localparam logic [PW-1:0] K_YG  = PW'(150);
    localparam logic [PW-1:0] K_YB  = PW'(29);
    localparam logic [PW-1:0] K_CBR = PW'(43);
    localparam logic [PW-1:0] K_CBG = PW'(85);
    localparam logic [PW-1:0] K_CBB = PW'(128);
    localparam logic [PW-1:0] K_CRR = PW'(128);
    localparam logic [PW-1:0] K_CRG = PW'(107);
    localparam logic [PW-1:0] K_CRB = PW'(21);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
    } rgb_t;

    function automatic logic signed [SW-1:0] sx(input logic [PW-1:0] p);
        return $signed({2'b00, p});
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] v);
        if (v[SW-1])
            return '0;
        else if (v > MAXV)
            return '1;
        else
            return v[DW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Input-side shadow registers: mode and window are frozen per frame
    // ------------------------------------------------------------------
    logic          vs_in_q;
    logic          vs_rise_in;
    logic [1:0]    mode_sh_q;
    logic [DW-1:0] cbmin_sh_q, cbmax_sh_q, crmin_sh_q, crmax_sh_q;

    assign vs_rise_in = in_vsync & ~vs_in_q;

    // Capture mode and thresholds at the rising edge of input vsync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_in_q    <= 1'b0;
            mode_sh_q  <= 2'b01;
            cbmin_sh_q <= DW'(CB_MIN);
            cbmax_sh_q <= DW'(CB_MAX);
            crmin_sh_q <= DW'(CR_MIN);
            crmax_sh_q <= DW'(CR_MAX);
        end else if (ce) begin
            vs_in_q <= in_vsync;
            if (vs_rise_in) begin
                mode_sh_q  <= mode;
                cbmin_sh_q <= cb_min;
                cbmax_sh_q <= cb_max;
                crmin_sh_q <= cr_min;
                crmax_sh_q <= cr_max;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1..S3 datapath with timing and raw RGB carried alongside
    // ------------------------------------------------------------------
    sync_t                sync_s1_q, sync_s2_q, sync_s3_q;
    rgb_t                 rgb_s1_q, rgb_s2_q, rgb_s3_q;
    logic [PW-1:0]        p_q [9];
    logic signed [SW-1:0] y_s2_q, cb_s2_q, cr_s2_q;
    logic [DW-1:0]        y_s3_q, cb_s3_q, cr_s3_q;

    // Delay timing and raw RGB by three stages to meet the S4 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1_q <= '0;
            sync_s2_q <= '0;
            sync_s3_q <= '0;
            rgb_s1_q  <= '0;
            rgb_s2_q  <= '0;
            rgb_s3_q  <= '0;
        end else if (ce) begin
            sync_s1_q <= '{hs: in_hsync, vs: in_vsync, de: in_de};
            sync_s2_q <= sync_s1_q;
            sync_s3_q <= sync_s2_q;
            rgb_s1_q  <= '{r: R, g: G, b: B};
            rgb_s2_q  <= rgb_s1_q;
            rgb_s3_q  <= rgb_s2_q;
        end
    end

    // S1: nine unsigned coefficient products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) p_q[i] <= '0;
        end else if (ce) begin
            p_q[0] <= {8'b0, R} * K_YR;
            p_q[1] <= {8'b0, G} * K_YG;
            p_q[2] <= {8'b0, B} * K_YB;
            p_q[3] <= {8'b0, R} * K_CBR;
            p_q[4] <= {8'b0, G} * K_CBG;
            p_q[5] <= {8'b0, B} * K_CBB;
            p_q[6] <= {8'b0, R} * K_CRR;
            p_q[7] <= {8'b0, G} * K_CRG;
            p_q[8] <= {8'b0, B} * K_CRB;
        end
    end

    // S2: signed sums, negative coefficients applied as subtraction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s2_q  <= '0;
            cb_s2_q <= '0;
            cr_s2_q <= '0;
        end else if (ce) begin
            y_s2_q  <= sx(p_q[0]) + sx(p_q[1]) + sx(p_q[2]);
            cb_s2_q <= sx(p_q[5]) - sx(p_q[3]) - sx(p_q[4]);
            cr_s2_q <= sx(p_q[6]) - sx(p_q[7]) - sx(p_q[8]);
        end
    end

    // S3: floor divide by 256, centre chroma, clamp to the component range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s3_q  <= '0;
            cb_s3_q <= '0;
            cr_s3_q <= '0;
        end else if (ce) begin
            y_s3_q  <= sat(y_s2_q >>> 8);
            cb_s3_q <= sat((cb_s2_q >>> 8) + OFF);
            cr_s3_q <= sat((cr_s2_q >>> 8) + OFF);
        end
    end

    // ------------------------------------------------------------------
    // S4: per-frame settings follow the vsync edge down the pipe
    // ------------------------------------------------------------------
    logic [1:0]    mode_s4_q;
    logic [DW-1:0] cbmin_s4_q, cbmax_s4_q, crmin_s4_q, crmax_s4_q;
    logic          hs_q, vs_q, de_q, skin_q;
    logic [DW-1:0] c0_q, c1_q, c2_q;

    logic          vs_rise_out;
    logic [1:0]    mode_e;
    logic [DW-1:0] cbmin_e, cbmax_e, crmin_e, crmax_e;
    logic          skin_d;
    logic [DW-1:0] c0_d, c1_d, c2_d;

    // Window compare and output mode mux; the frame's first sample already sees the new settings
    always_comb begin
        vs_rise_out = sync_s3_q.vs & ~vs_q;
        mode_e      = vs_rise_out ? mode_sh_q  : mode_s4_q;
        cbmin_e     = vs_rise_out ? cbmin_sh_q : cbmin_s4_q;
        cbmax_e     = vs_rise_out ? cbmax_sh_q : cbmax_s4_q;
        crmin_e     = vs_rise_out ? crmin_sh_q : crmin_s4_q;
        crmax_e     = vs_rise_out ? crmax_sh_q : crmax_s4_q;

        skin_d = sync_s3_q.de &&
                 (cb_s3_q >= cbmin_e) && (cb_s3_q <= cbmax_e) &&
                 (cr_s3_q >= crmin_e) && (cr_s3_q <= crmax_e);

        c0_d = '0;
        c1_d = '0;
        c2_d = '0;
        if (sync_s3_q.de) begin
            case (mode_e)
                2'b00: begin
                    c0_d = rgb_s3_q.r;
                    c1_d = rgb_s3_q.g;
                    c2_d = rgb_s3_q.b;
                end
                2'b01: begin
                    c0_d = y_s3_q;
                    c1_d = cb_s3_q;
                    c2_d = cr_s3_q;
                end
                2'b10: begin
                    c0_d = skin_d ? '1 : '0;
                    c1_d = skin_d ? '1 : '0;
                    c2_d = skin_d ? '1 : '0;
                end
                default: begin
                    c0_d = skin_d ? rgb_s3_q.r : '0;
                    c1_d = skin_d ? rgb_s3_q.g : '0;
                    c2_d = skin_d ? rgb_s3_q.b : '0;
                end
            endcase
        end
    end

    // Output registers plus the S4 copy of the per-frame settings
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            skin_q     <= 1'b0;
            c0_q       <= '0;
            c1_q       <= '0;
            c2_q       <= '0;
            mode_s4_q  <= 2'b01;
            cbmin_s4_q <= DW'(CB_MIN);
            cbmax_s4_q <= DW'(CB_MAX);
            crmin_s4_q <= DW'(CR_MIN);
            crmax_s4_q <= DW'(CR_MAX);
        end else if (ce) begin
            hs_q   <= sync_s3_q.hs;
            vs_q   <= sync_s3_q.vs;
            de_q   <= sync_s3_q.de;
            skin_q <= skin_d;
            c0_q   <= c0_d;
            c1_q   <= c1_d;
            c2_q   <= c2_d;
            if (vs_rise_out) begin
                mode_s4_q  <= mode_e;
                cbmin_s4_q <= cbmin_e;
                cbmax_s4_q <= cbmax_e;
                crmin_s4_q <= crmin_e;
                crmax_s4_q <= crmax_e;
            end
        end
    end

    assign out_hsync = hs_q;
    assign out_vsync = vs_q;
    assign out_de    = de_q;
    assign out_skin  = skin_q;
    assign out_c0    = c0_q;
    assign out_c1    = c1_q;
    assign out_c2    = c2_q;

`ifdef SKIN_COUNT_EN
    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    logic [CNT_W-1:0] acc_q, cnt_q;
    logic             cv_q;

    // Count skin pixels entering the output register; a pixel on the vsync-rise sample opens the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            cv_q  <= 1'b0;
        end else begin
            cv_q <= ce & vs_rise_out;
            if (ce) begin
                if (vs_rise_out) begin
                    cnt_q <= acc_q;
                    acc_q <= CNT_W'(skin_d);
                end else if (skin_d && (acc_q != ACC_MAX)) begin
                    acc_q <= acc_q + CNT_W'(1);
                end
            end
        end
    end

    assign skin_count  = cnt_q;
    assign count_valid = cv_q;
`else
    assign skin_count  = '0;
    assign count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_skin_segm_pipe.sv
module tb_skin_segm_pipe;
    logic        clk = 1'b0;
    logic        rst_n, ce, in_hsync, in_vsync, in_de;
    logic [7:0]  R, G, B;
    logic [1:0]  mode;
    logic [7:0]  cb_min, cb_max, cr_min, cr_max;
    logic        out_hsync, out_vsync, out_de, out_skin, count_valid;
    logic [7:0]  out_c0, out_c1, out_c2;
    logic [21:0] skin_count;

    int errors = 0;
    int checks = 0;

    skin_segm_pipe dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .R(R), .G(G), .B(B), .mode(mode),
        .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
        .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2),
        .out_skin(out_skin), .skin_count(skin_count), .count_valid(count_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] md;
        int cbmn, cbmx, crmn, crmx;
        int r, g, b;
        int e0, e1, e2, esk;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic de, input int r, input int g, input int b);
        in_de = de;
        R = 8'(r);
        G = 8'(g);
        B = 8'(b);
    endtask

    // vsync pulse with new mode/window, then idle long enough to flush the pipe
    task automatic frame_start(input logic [1:0] m, input int a, input int b, input int c, input int d);
        mode   = m;
        cb_min = 8'(a);
        cb_max = 8'(b);
        cr_min = 8'(c);
        cr_max = 8'(d);
        set_px(1'b0, 0, 0, 0);
        in_vsync = 1'b1;
        step();
        step();
        in_vsync = 1'b0;
        repeat (4) step();
    endtask

    task automatic chk_px(input string nm, input int e0, input int e1, input int e2);
        chk({nm, "_c0"}, int'(out_c0), e0);
        chk({nm, "_c1"}, int'(out_c1), e1);
        chk({nm, "_c2"}, int'(out_c2), e2);
    endtask

    function automatic bit is_skin_pos(input int l, input int x);
        case (l)
            0: return (x == 0) || (x == 1) || (x == 63);
            1: return (x == 10) || (x == 20);
            2: return (x >= 5) && (x <= 7);
            default: return (x == 0) || (x == 62);
        endcase
    endfunction

    initial begin
        int sent[$];
        int nce;
        int pix;
        int expv;
        int pulses;
        int cval;

        tbl[0]  = '{2'b01,  77, 127, 133, 173, 255, 255, 255, 255, 128, 128, 0};
        tbl[1]  = '{2'b01,  77, 127, 133, 173, 255,   0,   0,  76,  85, 255, 0};
        tbl[2]  = '{2'b01,  77, 127, 133, 173,   0,   0,   0,   0, 128, 128, 0};
        tbl[3]  = '{2'b01,  77, 127, 133, 173, 200, 150, 120, 161, 104, 155, 1};
        tbl[4]  = '{2'b10,  77, 127, 133, 173, 200, 150, 120, 255, 255, 255, 1};
        tbl[5]  = '{2'b11,  77, 127, 133, 173, 200, 150, 120, 200, 150, 120, 1};
        tbl[6]  = '{2'b00,  77, 127, 133, 173, 200, 150, 120, 200, 150, 120, 1};
        tbl[7]  = '{2'b11,  77, 127, 133, 173, 255,   0,   0,   0,   0,   0, 0};
        tbl[8]  = '{2'b10,  77, 127, 133, 173,   0,   0,   0,   0,   0,   0, 0};
        tbl[9]  = '{2'b00,  77, 127, 133, 173,  10,  20,  30,  10,  20,  30, 0};
        tbl[10] = '{2'b01,  77, 127, 133, 173,   0,   0, 255,  28, 255, 107, 0};
        tbl[11] = '{2'b01,  77, 127, 133, 173,   0, 255,   0, 149,  43,  21, 0};
        tbl[12] = '{2'b10, 104, 104, 155, 155, 200, 150, 120, 255, 255, 255, 1};
        tbl[13] = '{2'b10, 105, 127, 133, 173, 200, 150, 120,   0,   0,   0, 0};
        tbl[14] = '{2'b10, 127,  77, 133, 173, 200, 150, 120,   0,   0,   0, 0};
        tbl[15] = '{2'b10,  77, 127, 156, 173, 200, 150, 120,   0,   0,   0, 0};
        tbl[16] = '{2'b11,  77, 104, 133, 155, 200, 150, 120, 200, 150, 120, 1};

        rst_n = 1'b0; ce = 1'b1; in_hsync = 1'b0; in_vsync = 1'b0;
        mode = 2'b00; cb_min = 8'd77; cb_max = 8'd127; cr_min = 8'd133; cr_max = 8'd173;
        set_px(1'b0, 0, 0, 0);
        repeat (3) step();

        // Reset state
        chk_px("rst", 0, 0, 0);
        chk("rst_de", int'(out_de), 0);
        chk("rst_skin", int'(out_skin), 0);
        chk("rst_hs", int'(out_hsync), 0);
        chk("rst_vs", int'(out_vsync), 0);
        chk("rst_cnt", int'(skin_count), 0);
        chk("rst_cv", int'(count_valid), 0);
        rst_n = 1'b1;
        step();

        // Reset mode is YCbCr even without a vsync
        set_px(1'b1, 255, 0, 0);
        step();
        set_px(1'b0, 0, 0, 0);
        repeat (3) step();
        chk_px("rstmode", 76, 85, 255);
        chk("rstmode_de", int'(out_de), 1);

        // Table-driven vectors: one frame per vector, single pixel, 4-cycle latency
        for (int i = 0; i < NV; i++) begin
            frame_start(tbl[i].md, tbl[i].cbmn, tbl[i].cbmx, tbl[i].crmn, tbl[i].crmx);
            set_px(1'b1, tbl[i].r, tbl[i].g, tbl[i].b);
            step();
            set_px(1'b0, 0, 0, 0);
            repeat (3) step();
            chk_px($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2);
            chk($sformatf("vec%0d_skin", i), int'(out_skin), tbl[i].esk);
            chk($sformatf("vec%0d_de", i), int'(out_de), 1);
        end

        // hsync latency and de=0 data blanking
        frame_start(2'b00, 77, 127, 133, 173);
        in_hsync = 1'b1;
        set_px(1'b0, 200, 150, 120);
        step();
        in_hsync = 1'b0;
        set_px(1'b0, 0, 0, 0);
        step();
        step();
        chk("hs_early", int'(out_hsync), 0);
        step();
        chk("hs_lat4", int'(out_hsync), 1);
        chk_px("de0_blank", 0, 0, 0);
        chk("de0_skin", int'(out_skin), 0);
        step();
        chk("hs_after", int'(out_hsync), 0);

        // Mid-frame mode write only takes effect after the next vsync rise
        frame_start(2'b00, 77, 127, 133, 173);
        mode = 2'b01;
        set_px(1'b1, 200, 150, 120);
        step();
        set_px(1'b0, 0, 0, 0);
        repeat (3) step();
        chk_px("midmode_old", 200, 150, 120);
        frame_start(2'b01, 77, 127, 133, 173);
        set_px(1'b1, 200, 150, 120);
        step();
        set_px(1'b0, 0, 0, 0);
        repeat (3) step();
        chk_px("midmode_new", 161, 104, 155);

        // ce stall mid-line: frozen outputs, then the exact sequence resumes
        frame_start(2'b00, 77, 127, 133, 173);
        nce = 0;
        pix = 1;
        for (int t = 0; t < 20; t++) begin
            ce = !(t >= 6 && t <= 8);
            set_px(1'b1, pix * 7, 0, 0);
            if (ce) begin
                sent.push_back(pix * 7);
                pix++;
            end
            step();
            if (ce) nce++;
            expv = (nce >= 4) ? sent[nce - 4] : 0;
            chk($sformatf("ce_t%0d_c0", t), int'(out_c0), expv);
            chk($sformatf("ce_t%0d_de", t), int'(out_de), (nce >= 4) ? 1 : 0);
        end
        ce = 1'b1;
        set_px(1'b0, 0, 0, 0);
        repeat (4) step();

        // Reset asserted mid-frame clears outputs at once and restores mode 01
        frame_start(2'b00, 77, 127, 133, 173);
        set_px(1'b1, 200, 150, 120);
        repeat (5) step();
        chk("midrst_pre_de", int'(out_de), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_de", int'(out_de), 0);
        chk("midrst_c0", int'(out_c0), 0);
        step();
        rst_n = 1'b1;
        step();
        set_px(1'b1, 200, 150, 120);
        step();
        set_px(1'b0, 0, 0, 0);
        repeat (3) step();
        chk_px("postrst", 161, 104, 155);

`ifdef SKIN_COUNT_EN
        // 64x4 frame with 10 skin pixels
        frame_start(2'b10, 77, 127, 133, 173);
        for (int l = 0; l < 4; l++) begin
            for (int x = 0; x < 64; x++) begin
                if (is_skin_pos(l, x)) set_px(1'b1, 200, 150, 120);
                else set_px(1'b1, 0, 0, 0);
                step();
            end
            set_px(1'b0, 0, 0, 0);
            in_hsync = 1'b1;
            repeat (4) step();
            in_hsync = 1'b0;
            repeat (4) step();
        end
        pulses = 0;
        cval = -1;
        in_vsync = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t == 2) in_vsync = 1'b0;
            step();
            if (count_valid) begin
                pulses++;
                cval = int'(skin_count);
                chk("cnt_vs_align", int'(out_vsync), 1);
            end
        end
        chk("cnt_pulses", pulses, 1);
        chk("cnt_value", cval, 10);
`else
        // Counter absent: outputs tied low even after skin traffic
        pulses = 0;
        frame_start(2'b10, 77, 127, 133, 173);
        set_px(1'b1, 200, 150, 120);
        step();
        set_px(1'b0, 0, 0, 0);
        frame_start(2'b10, 77, 127, 133, 173);
        chk("nocnt_value", int'(skin_count), 0);
        chk("nocnt_valid", int'(count_valid), pulses);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
